// File: rtl/bids22_cmd_feeder.sv
`default_nettype none
// ============================================================================
// Module  : bids22_cmd_feeder
// Purpose : Command FIFO that feeds an auctioneer with one-cycle ops and
//           counted rounds. Define BIDS22_FEEDER_ERRHALT_EN to halt on error.
// Revision: 1.0
// ============================================================================
module bids22_cmd_feeder #(
    parameter int DATAWIDTH = 32,
    parameter int OPW       = 4,
    parameter int ERRW      = 3,
    parameter int DEPTH     = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push_valid,
    output logic                     push_ready,
    input  logic [OPW-1:0]           push_op,
    input  logic [DATAWIDTH-1:0]     push_data,
    input  logic                     push_start,
    input  logic                     ready,
    input  logic [ERRW-1:0]          err,
    output logic [OPW-1:0]           C_op,
    output logic [DATAWIDTH-1:0]     C_data,
    output logic                     C_start,
    input  logic                     clear_halt,
    output logic                     halted,
    output logic [ERRW-1:0]          err_capt,
    output logic [OPW-1:0]           err_op,
    output logic [7:0]               err_count,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int AW = $clog2(DEPTH);
    localparam int EW = DATAWIDTH + OPW + 1;
    localparam logic [AW-1:0]        PTR_ONE  = AW'(1);
    localparam logic [AW:0]          LVL_ONE  = (AW+1)'(1);
    localparam logic [AW:0]          LVL_FULL = (AW+1)'(DEPTH);
    localparam logic [DATAWIDTH-1:0] CNT_ONE  = DATAWIDTH'(1);
`ifdef BIDS22_FEEDER_ERRHALT_EN
    localparam logic HALT_EN = 1'b1;
`else
    localparam logic HALT_EN = 1'b0;
`endif

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        ROUND = 2'd2,
        HALT  = 2'd3
    } state_t;

    state_t                 state_q, state_d;
    logic [EW-1:0]          mem_q [DEPTH];
    logic [AW-1:0]          wptr_q, wptr_d, rptr_q, rptr_d;
    logic [AW:0]            level_q, level_d;
    logic [OPW-1:0]         cop_q, cop_d;
    logic [DATAWIDTH-1:0]   cdata_q, cdata_d;
    logic                   cstart_q, cstart_d;
    logic [DATAWIDTH-1:0]   cnt_q, cnt_d;
    logic                   pend_q, pend_d;
    logic                   capt_vld_q, capt_vld_d;
    logic [ERRW-1:0]        ecapt_q, ecapt_d;
    logic [OPW-1:0]         eop_q, eop_d;
    logic [7:0]             ecnt_q, ecnt_d;

    logic                   push_acc, pop, err_hit;
    logic                   head_start;
    logic [OPW-1:0]         head_op;
    logic [DATAWIDTH-1:0]   head_data;

    assign push_ready = (level_q != LVL_FULL);

    always_comb begin
        push_acc   = push_valid && push_ready;
        {head_start, head_op, head_data} = mem_q[rptr_q];
        err_hit    = ((state_q == ISSUE) || (state_q == ROUND)) && (err != '0);
        pop        = 1'b0;
        state_d    = state_q;
        cop_d      = '0;
        cdata_d    = '0;
        cstart_d   = 1'b0;
        cnt_d      = cnt_q;
        pend_d     = pend_q;
        capt_vld_d = capt_vld_q;
        ecapt_d    = ecapt_q;
        eop_d      = eop_q;
        ecnt_d     = ecnt_q;

        case (state_q)
            IDLE: begin
                if ((level_q != '0) && ready) begin
                    pop     = 1'b1;
                    cdata_d = head_data;
                    if (head_start) begin
                        state_d  = ROUND;
                        cstart_d = 1'b1;
                        cnt_d    = (head_data == '0) ? CNT_ONE : head_data;
                    end else begin
                        state_d = ISSUE;
                        cop_d   = head_op;
                    end
                end
            end
            ISSUE: begin
                state_d = (HALT_EN && err_hit) ? HALT : IDLE;
            end
            ROUND: begin
                // An error mid-round is remembered so the round still runs to length.
                if (err_hit) begin
                    pend_d = 1'b1;
                end
                if (cnt_q == CNT_ONE) begin
                    state_d = (HALT_EN && (pend_q || err_hit)) ? HALT : IDLE;
                    pend_d  = 1'b0;
                end else begin
                    cnt_d    = cnt_q - CNT_ONE;
                    cstart_d = 1'b1;
                    cdata_d  = cdata_q;
                end
            end
            HALT: begin
                if (clear_halt) begin
                    state_d    = IDLE;
                    capt_vld_d = 1'b0;
                    ecapt_d    = '0;
                    eop_d      = '0;
                end
            end
            default: state_d = IDLE;
        endcase

        if (err_hit) begin
            if (ecnt_q != 8'hFF) begin
                ecnt_d = ecnt_q + 8'd1;
            end
            if (!capt_vld_q) begin
                capt_vld_d = 1'b1;
                ecapt_d    = err;
                eop_d      = cop_q;
            end
        end

        wptr_d = push_acc ? (wptr_q + PTR_ONE) : wptr_q;
        rptr_d = pop ? (rptr_q + PTR_ONE) : rptr_q;
        case ({push_acc, pop})
            2'b10:   level_d = level_q + LVL_ONE;
            2'b01:   level_d = level_q - LVL_ONE;
            default: level_d = level_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            wptr_q     <= '0;
            rptr_q     <= '0;
            level_q    <= '0;
            cop_q      <= '0;
            cdata_q    <= '0;
            cstart_q   <= 1'b0;
            cnt_q      <= '0;
            pend_q     <= 1'b0;
            capt_vld_q <= 1'b0;
            ecapt_q    <= '0;
            eop_q      <= '0;
            ecnt_q     <= '0;
        end else begin
            state_q    <= state_d;
            wptr_q     <= wptr_d;
            rptr_q     <= rptr_d;
            level_q    <= level_d;
            cop_q      <= cop_d;
            cdata_q    <= cdata_d;
            cstart_q   <= cstart_d;
            cnt_q      <= cnt_d;
            pend_q     <= pend_d;
            capt_vld_q <= capt_vld_d;
            ecapt_q    <= ecapt_d;
            eop_q      <= eop_d;
            ecnt_q     <= ecnt_d;
        end
    end

    // Storage needs no reset: occupancy is governed solely by the pointers.
    always_ff @(posedge clk) begin
        if (push_acc) begin
            mem_q[wptr_q] <= {push_start, push_op, push_data};
        end
    end

    assign C_op      = cop_q;
    assign C_data    = cdata_q;
    assign C_start   = cstart_q;
    assign err_capt  = ecapt_q;
    assign err_op    = eop_q;
    assign err_count = ecnt_q;
    assign level     = level_q;
`ifdef BIDS22_FEEDER_ERRHALT_EN
    assign halted    = (state_q == HALT);
`else
    assign halted    = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_bids22_cmd_feeder.sv
`default_nettype none
// ============================================================================
// Module  : tb_bids22_cmd_feeder
// Purpose : Scoreboard bench for bids22_cmd_feeder (honours
//           BIDS22_FEEDER_ERRHALT_EN the same way as the design).
// Revision: 1.0
// ============================================================================
module tb_bids22_cmd_feeder;

    localparam int DW    = 32;
    localparam int OPW   = 4;
    localparam int ERRW  = 3;
    localparam int DEPTH = 8;
    localparam int LW    = $clog2(DEPTH) + 1;
    localparam logic [OPW-1:0] OP_LOADX  = 4'd1;
    localparam logic [OPW-1:0] OP_UNLOCK = 4'd2;

    logic            clk = 1'b0;
    logic            reset, push_valid, push_ready, push_start, ready;
    logic [OPW-1:0]  push_op, C_op, err_op;
    logic [DW-1:0]   push_data, C_data;
    logic [ERRW-1:0] err, err_capt;
    logic            C_start, clear_halt, halted, inj_en;
    logic [7:0]      err_count;
    logic [LW-1:0]   level;

    typedef struct {
        logic [OPW-1:0] op;
        logic [DW-1:0]  data;
        logic           start;
    } exp_t;

    exp_t sb_q[$];
    exp_t mon_e;
    int   n_checks = 0;
    int   n_fail   = 0;
    bit   in_round = 1'b0;
    int   rlen     = 0;
    int   exp_len  = 0;
    bit   acc;

    always #5 clk = ~clk;

    // Controller model: UNLOCK raises error code 1 while injection is armed.
    assign err = (inj_en && (C_op == OP_UNLOCK)) ? 3'd1 : 3'd0;

    bids22_cmd_feeder #(
        .DATAWIDTH(DW), .OPW(OPW), .ERRW(ERRW), .DEPTH(DEPTH)
    ) dut (
        .clk(clk), .reset(reset),
        .push_valid(push_valid), .push_ready(push_ready),
        .push_op(push_op), .push_data(push_data), .push_start(push_start),
        .ready(ready), .err(err),
        .C_op(C_op), .C_data(C_data), .C_start(C_start),
        .clear_halt(clear_halt), .halted(halted),
        .err_capt(err_capt), .err_op(err_op), .err_count(err_count),
        .level(level)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Called at posedge+1; offers one command across the next edge.
    task automatic push_cmd(input logic [OPW-1:0] op, input logic [DW-1:0] data,
                            input logic st, output bit accepted);
        exp_t e;
        push_valid = 1'b1;
        push_op    = op;
        push_data  = data;
        push_start = st;
        @(negedge clk);
        accepted = push_ready;
        if (accepted) begin
            e.op    = st ? '0 : op;
            e.data  = data;
            e.start = st;
            sb_q.push_back(e);
        end
        @(posedge clk);
        #1;
        push_valid = 1'b0;
    endtask

    task automatic wait_drain(input string tag);
        int n;
        n = 0;
        while ((sb_q.size() != 0 || in_round) && n < 300) begin
            @(negedge clk);
            n++;
        end
        check_eq(tag, sb_q.size(), 0);
        @(posedge clk);
        #1;
    endtask

    // Output monitor: every issued op or round is matched against the queue.
    always @(negedge clk) begin
        if (reset) begin
            sb_q.delete();
            in_round = 1'b0;
        end else begin
            if (C_op != '0) begin
                if (sb_q.size() == 0) begin
                    check_eq("sb_unexpected_op", C_op, 0);
                end else begin
                    mon_e = sb_q.pop_front();
                    check_eq("sb_op", C_op, mon_e.op);
                    check_eq("sb_data", C_data, mon_e.data);
                    check_eq("sb_kind_issue", C_start, mon_e.start);
                end
            end
            if (C_start && !in_round) begin
                if (sb_q.size() == 0) begin
                    check_eq("sb_unexpected_round", C_start, 0);
                end else begin
                    mon_e = sb_q.pop_front();
                    check_eq("round_kind", C_start, mon_e.start);
                    check_eq("round_data", C_data, mon_e.data);
                    check_eq("round_op", C_op, 0);
                    exp_len  = (mon_e.data == 0) ? 1 : int'(mon_e.data);
                    rlen     = 1;
                    in_round = 1'b1;
                end
            end else if (C_start && in_round) begin
                rlen++;
            end else if (!C_start && in_round) begin
                check_eq("round_len", rlen, exp_len);
                in_round = 1'b0;
            end
        end
    end

    initial begin
        int n;
        reset      = 1'b1;
        push_valid = 1'b0;
        push_op    = '0;
        push_data  = '0;
        push_start = 1'b0;
        ready      = 1'b0;
        clear_halt = 1'b0;
        inj_en     = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;

        // Reset state
        @(negedge clk);
        check_eq("rst_C_op", C_op, 0);
        check_eq("rst_C_data", C_data, 0);
        check_eq("rst_C_start", C_start, 0);
        check_eq("rst_halted", halted, 0);
        check_eq("rst_err_capt", err_capt, 0);
        check_eq("rst_err_op", err_op, 0);
        check_eq("rst_err_count", err_count, 0);
        check_eq("rst_level", level, 0);
        check_eq("rst_push_ready", push_ready, 1);
        @(posedge clk);
        #1;

        // Latency: push at edge t, op visible in the cycle ending at edge t+2
        ready = 1'b1;
        push_cmd(OP_LOADX, 32'd100, 1'b0, acc);
        @(negedge clk);
        check_eq("lat_t1_op", C_op, 0);
        @(negedge clk);
        check_eq("lat_t2_op", C_op, OP_LOADX);
        check_eq("lat_t2_data", C_data, 100);
        @(negedge clk);
        check_eq("lat_t3_op", C_op, 0);
        wait_drain("lat_drain");

        // Simultaneous push and pop keeps level constant
        ready = 1'b0;
        push_cmd(OP_LOADX, 32'd11, 1'b0, acc);
        push_cmd(4'd3, 32'd12, 1'b0, acc);
        ready = 1'b1;
        push_cmd(4'd4, 32'd13, 1'b0, acc);
        @(negedge clk);
        check_eq("pushpop_level", level, 2);
        wait_drain("pushpop_drain");

        // Fill to capacity with ready low, reject ninth, then drain in order
        ready = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            push_cmd(OPW'(i + 1), $urandom, 1'b0, acc);
        end
        @(negedge clk);
        check_eq("full_push_ready", push_ready, 0);
        check_eq("full_level", level, DEPTH);
        @(posedge clk);
        #1;
        push_cmd(4'd9, 32'd99, 1'b0, acc);
        check_eq("full_reject", acc, 0);
        @(negedge clk);
        check_eq("full_level_after", level, DEPTH);
        @(posedge clk);
        #1;
        ready = 1'b1;
        wait_drain("full_drain");
        @(negedge clk);
        check_eq("full_empty_level", level, 0);
        @(posedge clk);
        #1;

        // Rounds of length 5 and zero (treated as one)
        push_cmd(4'd5, 32'd5, 1'b1, acc);
        wait_drain("round5_drain");
        push_cmd(4'd6, 32'd0, 1'b1, acc);
        wait_drain("round0_drain");

        // Controller error on UNLOCK
        ready  = 1'b0;
        inj_en = 1'b1;
        push_cmd(OP_UNLOCK, 32'd7, 1'b0, acc);
        push_cmd(OP_LOADX, 32'd9, 1'b0, acc);
        ready = 1'b1;
        n = 0;
        while (C_op != OP_UNLOCK && n < 40) begin
            @(negedge clk);
            n++;
        end
        check_eq("unlock_seen", C_op, OP_UNLOCK);
        @(negedge clk);
        check_eq("err_count", err_count, 1);
        check_eq("err_capt", err_capt, 1);
        check_eq("err_op", err_op, OP_UNLOCK);
`ifdef BIDS22_FEEDER_ERRHALT_EN
        check_eq("halted_set", halted, 1);
        repeat (4) @(negedge clk);
        check_eq("halt_frozen_level", level, 1);
        check_eq("halt_C_op", C_op, 0);
        check_eq("halt_held", halted, 1);
        @(posedge clk);
        #1;
        clear_halt = 1'b1;
        @(posedge clk);
        #1;
        clear_halt = 1'b0;
        @(negedge clk);
        check_eq("clr_halted", halted, 0);
        check_eq("clr_err_capt", err_capt, 0);
        check_eq("clr_err_op", err_op, 0);
        check_eq("clr_err_count_kept", err_count, 1);
`else
        check_eq("nohalt_halted", halted, 0);
        @(negedge clk);
        check_eq("nohalt_no_stall", C_op, OP_LOADX);
        check_eq("nohalt_halted2", halted, 0);
`endif
        wait_drain("err_resume_drain");
        inj_en = 1'b0;

        // Reset on the third cycle of a ten-cycle round with four queued
        ready = 1'b0;
        push_cmd(4'd7, 32'd10, 1'b1, acc);
        for (int i = 0; i < 4; i++) begin
            push_cmd(OP_LOADX, DW'(20 + i), 1'b0, acc);
        end
        ready = 1'b1;
        n = 0;
        while (!C_start && n < 20) begin
            @(negedge clk);
            n++;
        end
        check_eq("rr_round_seen", C_start, 1);
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        reset      = 1'b1;
        push_valid = 1'b1;
        push_op    = OP_LOADX;
        push_data  = 32'd77;
        push_start = 1'b0;
        clear_halt = 1'b1;
        @(posedge clk);
        #1;
        reset      = 1'b0;
        push_valid = 1'b0;
        clear_halt = 1'b0;
        @(negedge clk);
        check_eq("rr_C_start", C_start, 0);
        check_eq("rr_C_op", C_op, 0);
        check_eq("rr_C_data", C_data, 0);
        check_eq("rr_level", level, 0);
        check_eq("rr_halted", halted, 0);
        check_eq("rr_err_capt", err_capt, 0);
        check_eq("rr_err_op", err_op, 0);
        check_eq("rr_err_count", err_count, 0);
        repeat (6) @(negedge clk);
        check_eq("rr_discarded_level", level, 0);
        check_eq("rr_discarded_op", C_op, 0);
        check_eq("rr_discarded_start", C_start, 0);
        check_eq("sb_final_empty", sb_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
